// File: rtl/imem_fetch_responder.sv
// Instruction memory with a one-cycle fetch responder for a simple in-order core.
// The memory is boot-loaded in BOOT, then served read-only in RUN under stall/flush control.
module imem_fetch_responder #(
  parameter int          address_width = 12,
  parameter logic [31:0] NOP_INSTR     = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [address_width-1:0] req_addr,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     load_en,
  input  logic [address_width-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic                     load_done,
  output logic                     resp_valid,
  output logic [31:0]              resp_instr,
  output logic [address_width-1:0] resp_pc,
  output logic                     misaligned,
  output logic                     ready
);

  localparam int depth = 2 ** (address_width - 2);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;

  logic [31:0]              mem [depth];
  logic [address_width-3:0] fetch_idx;
  logic [address_width-3:0] load_idx;
  logic                     fetch_aligned;
  logic                     unused_load_lsbs;

  assign fetch_idx        = req_addr[address_width-1:2];
  assign load_idx         = load_addr[address_width-1:2];
  assign fetch_aligned    = (req_addr[1:0] == 2'b00);
  assign unused_load_lsbs = ^load_addr[1:0];
  assign ready            = (state == RUN);

  // Memory has no reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (state == BOOT && load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      resp_valid <= 1'b0;
      resp_instr <= NOP_INSTR;
      resp_pc    <= '0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          resp_valid <= 1'b0;
          resp_instr <= NOP_INSTR;
          misaligned <= 1'b0;
          if (load_done) begin
            state <= RUN;
          end
        end
        RUN: begin
          // Flush beats stall beats a new fetch; a stalled request is simply dropped.
          if (flush) begin
            resp_valid <= 1'b0;
            resp_instr <= NOP_INSTR;
            misaligned <= 1'b0;
          end else if (stall) begin
            resp_valid <= resp_valid;
          end else if (req_valid) begin
            resp_valid <= 1'b1;
            resp_pc    <= req_addr;
            misaligned <= ~fetch_aligned;
            resp_instr <= fetch_aligned ? mem[fetch_idx] : NOP_INSTR;
          end else begin
            resp_valid <= 1'b0;
            resp_instr <= NOP_INSTR;
            misaligned <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed, table-driven bench for imem_fetch_responder: one vector per clock,
// outputs compared 1 ns after the rising edge against hand-computed values.
module tb_imem_fetch_responder;

  localparam int          AW  = 12;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          stall;
  logic          flush;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          load_done;
  logic          resp_valid;
  logic [31:0]   resp_instr;
  logic [AW-1:0] resp_pc;
  logic          misaligned;
  logic          ready;

  int checks = 0;
  int failures = 0;

  imem_fetch_responder #(.address_width(AW), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .stall     (stall),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_done (load_done),
    .resp_valid(resp_valid),
    .resp_instr(resp_instr),
    .resp_pc   (resp_pc),
    .misaligned(misaligned),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          rv;
    logic [AW-1:0] ra;
    logic          st;
    logic          fl;
    logic          le;
    logic [AW-1:0] la;
    logic [31:0]   ld;
    logic          done;
    logic          e_ready;
    logic          e_valid;
    logic [31:0]   e_instr;
    logic [AW-1:0] e_pc;
    logic          e_mis;
    logic          chk_pc;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic rv, input logic [AW-1:0] ra, input logic st, input logic fl,
    input logic le, input logic [AW-1:0] la, input logic [31:0] ld, input logic done,
    input logic er, input logic ev, input logic [31:0] ei, input logic [AW-1:0] ep,
    input logic em, input logic cp);
    vec_t v;
    v.rst = rst; v.rv = rv; v.ra = ra; v.st = st; v.fl = fl;
    v.le = le; v.la = la; v.ld = ld; v.done = done;
    v.e_ready = er; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_mis = em; v.chk_pc = cp;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    req_valid = v.rv;
    req_addr  = v.ra;
    stall     = v.st;
    flush     = v.fl;
    load_en   = v.le;
    load_addr = v.la;
    load_data = v.ld;
    load_done = v.done;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    checkOutput({tag, " ready"},      {31'd0, ready},      {31'd0, v.e_ready});
    checkOutput({tag, " resp_valid"}, {31'd0, resp_valid}, {31'd0, v.e_valid});
    checkOutput({tag, " resp_instr"}, resp_instr,          v.e_instr);
    checkOutput({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, v.e_mis});
    if (v.chk_pc) begin
      checkOutput({tag, " resp_pc"}, {20'd0, resp_pc}, {20'd0, v.e_pc});
    end
  endtask

  vec_t tbl[19];
  vec_t hv;

  initial begin
    // rst rv ra st fl le la ld done | ready valid instr pc mis chk_pc
    tbl[0]  = mk(1, 0, 12'h000, 0, 0, 0, 12'h000, 32'h0,         0, 0, 0, NOP,          12'h000, 0, 1);
    tbl[1]  = mk(0, 0, 12'h000, 0, 0, 1, 12'h000, 32'hAAAA0001,  0, 0, 0, NOP,          12'h000, 0, 1);
    tbl[2]  = mk(0, 0, 12'h000, 0, 0, 1, 12'h004, 32'hBBBB0002,  0, 0, 0, NOP,          12'h000, 0, 1);
    // Write and load_done together; the BOOT-time request must be ignored.
    tbl[3]  = mk(0, 1, 12'h000, 0, 0, 1, 12'h00B, 32'h11112222,  1, 1, 0, NOP,          12'h000, 0, 1);
    tbl[4]  = mk(0, 1, 12'h000, 0, 0, 0, 12'h000, 32'h0,         0, 1, 1, 32'hAAAA0001, 12'h000, 0, 1);
    tbl[5]  = mk(0, 1, 12'h004, 0, 0, 0, 12'h000, 32'h0,         0, 1, 1, 32'hBBBB0002, 12'h004, 0, 1);
    tbl[6]  = mk(0, 1, 12'h008, 0, 0, 0, 12'h000, 32'h0,         0, 1, 1, 32'h11112222, 12'h008, 0, 1);
    tbl[7]  = mk(0, 0, 12'h000, 0, 0, 0, 12'h000, 32'h0,         0, 1, 0, NOP,          12'h000, 0, 0);
    tbl[8]  = mk(0, 1, 12'h004, 0, 0, 0, 12'h000, 32'h0,         0, 1, 1, 32'hBBBB0002, 12'h004, 0, 1);
    tbl[9]  = mk(0, 1, 12'h000, 1, 0, 0, 12'h000, 32'h0,         0, 1, 1, 32'hBBBB0002, 12'h004, 0, 1);
    tbl[10] = mk(0, 1, 12'h008, 1, 0, 0, 12'h000, 32'h0,         0, 1, 1, 32'hBBBB0002, 12'h004, 0, 1);
    tbl[11] = mk(0, 0, 12'h000, 1, 0, 0, 12'h000, 32'h0,         0, 1, 1, 32'hBBBB0002, 12'h004, 0, 1);
    tbl[12] = mk(0, 1, 12'h000, 1, 1, 0, 12'h000, 32'h0,         0, 1, 0, NOP,          12'h004, 0, 1);
    tbl[13] = mk(0, 1, 12'h006, 0, 0, 0, 12'h000, 32'h0,         0, 1, 1, NOP,          12'h006, 1, 1);
    tbl[14] = mk(0, 1, 12'h000, 1, 0, 0, 12'h000, 32'h0,         0, 1, 1, NOP,          12'h006, 1, 1);
    tbl[15] = mk(0, 1, 12'h004, 0, 1, 0, 12'h000, 32'h0,         0, 1, 0, NOP,          12'h006, 0, 1);
    tbl[16] = mk(0, 0, 12'h000, 0, 0, 1, 12'h000, 32'hDEADBEEF,  0, 1, 0, NOP,          12'h000, 0, 0);
    tbl[17] = mk(0, 1, 12'h000, 0, 0, 0, 12'h000, 32'h0,         0, 1, 1, 32'hAAAA0001, 12'h000, 0, 1);
    tbl[18] = mk(0, 1, 12'h004, 0, 0, 0, 12'h000, 32'h0,         1, 1, 1, 32'hBBBB0002, 12'h004, 0, 1);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i]);
      checkVector($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset mid-stream with a request present: response dropped, back to BOOT.
    hv = mk(1, 1, 12'h004, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, NOP, 12'h000, 0, 1);
    applyStimulus(hv);
    checkVector("rst_assert", hv);

    // Without load_done, fetches stay unserved.
    hv = mk(0, 1, 12'h000, 0, 0, 0, 12'h000, 32'h0, 0, 0, 0, NOP, 12'h000, 0, 1);
    applyStimulus(hv);
    checkVector("rst_noload_a", hv);
    applyStimulus(hv);
    checkVector("rst_noload_b", hv);

    hv = mk(0, 0, 12'h000, 0, 0, 0, 12'h000, 32'h0, 1, 1, 0, NOP, 12'h000, 0, 1);
    applyStimulus(hv);
    checkVector("rst_reload", hv);

    // Memory contents must have survived the reset.
    hv = mk(0, 1, 12'h000, 0, 0, 0, 12'h000, 32'h0, 0, 1, 1, 32'hAAAA0001, 12'h000, 0, 1);
    applyStimulus(hv);
    checkVector("rst_fetch0", hv);
    hv = mk(0, 1, 12'h008, 0, 0, 0, 12'h000, 32'h0, 0, 1, 1, 32'h11112222, 12'h008, 0, 1);
    applyStimulus(hv);
    checkVector("rst_fetch8", hv);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
